// File: rtl/tetris_pkg.sv
// Shared board geometry, score width and the row_clear FSM state encoding.
package tetris_pkg;

    localparam int BLOCKS_WIDE = 10;
    localparam int BLOCKS_HIGH = 22;
    localparam int BITS_Y_POS  = 5;
    localparam int BITS_SCORE  = 14;
    localparam int BOARD_BITS  = BLOCKS_WIDE * BLOCKS_HIGH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        SETTLE = 2'd3
    } row_clear_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that increments on inc and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/row_clear.sv
// Removes one full row from the fallen-pieces board per pass, shifting the rows
// above it down one row per clock, then strobes the edited board back to its owner.
module row_clear
    import tetris_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pause,
    input  logic [BITS_Y_POS-1:0] full_row,
    input  logic                  full_valid,
    input  logic [BOARD_BITS-1:0] board_in,
    output logic [BOARD_BITS-1:0] board_out,
    output logic                  board_we,
    output logic                  scan_pause,
    output logic                  busy,
    output logic [BITS_SCORE-1:0] score,
    output row_clear_state_t      dbg_state
);

    row_clear_state_t      state_q, state_d;
    logic [BITS_Y_POS-1:0] r_q;
    logic [BITS_Y_POS-1:0] r_above;
    logic [BOARD_BITS-1:0] board_q;
    logic                  accept;

    // Handshake: full_valid/full_row is taken only in IDLE with pause low; there is
    // no ready wire, instead scan_pause freezes the scanner so its report stays
    // coherent with the board until this block is back in IDLE.
    assign accept  = (state_q == IDLE) && full_valid && !pause
                     && (full_row < BITS_Y_POS'(BLOCKS_HIGH));
    assign r_above = r_q - 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (r_q == '0) state_d = COMMIT;
            COMMIT:  state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            board_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        board_q <= board_in;
                        r_q     <= full_row;
                    end
                end
                SHIFT: begin
                    // Walk upward from the cleared row; row 0 has nothing above it.
                    if (r_q == '0) begin
                        board_q[0 +: BLOCKS_WIDE] <= '0;
                    end else begin
                        board_q[int'(r_q) * BLOCKS_WIDE +: BLOCKS_WIDE] <=
                            board_q[int'(r_above) * BLOCKS_WIDE +: BLOCKS_WIDE];
                        r_q <= r_above;
                    end
                end
                default: ;
            endcase
        end
    end

    sat_counter #(
        .WIDTH(BITS_SCORE)
    ) u_score (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (state_q == COMMIT),
        .count(score)
    );

    assign board_out  = board_q;
    assign board_we   = (state_q == COMMIT);
    assign busy       = (state_q != IDLE);
    assign scan_pause = busy | pause;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_row_clear.sv
// Directed bench for row_clear: table of single clears, ignored requests,
// back-to-back clears, reset mid-shift and score saturation.
module tb_row_clear;
    import tetris_pkg::*;

    localparam int BW = BOARD_BITS;

    logic                  clk;
    logic                  rst_n;
    logic                  pause;
    logic [BITS_Y_POS-1:0] full_row;
    logic                  full_valid;
    logic [BW-1:0]         board_in;
    logic [BW-1:0]         board_out;
    logic                  board_we;
    logic                  scan_pause;
    logic                  busy;
    logic [BITS_SCORE-1:0] score;
    row_clear_state_t      dbg_state;

    int tests = 0;
    int fails = 0;
    int exp_score = 0;
    bit sb_en = 1'b1;
    logic [BW-1:0] exp_q[$];

    row_clear dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pause     (pause),
        .full_row  (full_row),
        .full_valid(full_valid),
        .board_in  (board_in),
        .board_out (board_out),
        .board_we  (board_we),
        .scan_pause(scan_pause),
        .busy      (busy),
        .score     (score),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n      = 1'b0;
        pause      = 1'b0;
        full_row   = '0;
        full_valid = 1'b0;
        board_in   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_score = 0;
    endtask

    task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] put_row(input logic [BW-1:0] b, input int idx, input logic [9:0] val);
        logic [BW-1:0] t;
        t = b;
        t[idx*BLOCKS_WIDE +: BLOCKS_WIDE] = t[idx*BLOCKS_WIDE +: BLOCKS_WIDE] | val;
        return t;
    endfunction

    // scoreboard: every strobe must match the oldest expected board
    always @(negedge clk) begin
        if (rst_n && sb_en && board_we) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_we", 1, 0);
            end else begin
                check("sb_board", board_out, exp_q.pop_front());
            end
        end
    end

    // driver: one full clear of row r, checking timing, board and score
    task automatic run_clear(input logic [4:0] r, input logic [BW-1:0] b, input logic [BW-1:0] e);
        int cyc;
        @(negedge clk);
        board_in   = b;
        full_row   = r;
        full_valid = 1'b1;
        if (sb_en) exp_q.push_back(e);
        @(posedge clk);
        #1;
        full_valid = 1'b0;
        board_in   = ~b;
        check("busy_after_accept", busy, 1);
        check("scan_pause_busy", scan_pause, 1);
        cyc = 1;
        while (!board_we && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("we_latency", cyc, r + 2);
        check("board_out", board_out, e);
        @(posedge clk);
        #1;
        exp_score = (exp_score == 16383) ? 16383 : exp_score + 1;
        check("we_one_cycle", board_we, 0);
        check("busy_settle", busy, 1);
        check("score", score, exp_score);
        @(posedge clk);
        #1;
        check("idle_after_settle", busy, 0);
    endtask

    typedef struct {
        logic [4:0] r;
        int         in_idx[4];
        logic [9:0] in_val[4];
        int         ex_idx[4];
        logic [9:0] ex_val[4];
    } vec_t;

    vec_t vt[5];

    initial begin
        logic [BW-1:0] b, e, b0, e1, e2;
        int pulses;

        vt[0].r = 5'd21;
        vt[0].in_idx = '{21, 20, 0, 0};  vt[0].in_val = '{10'h3FF, 10'h001, 10'h0, 10'h0};
        vt[0].ex_idx = '{21, 0, 0, 0};   vt[0].ex_val = '{10'h001, 10'h0, 10'h0, 10'h0};
        vt[1].r = 5'd0;
        vt[1].in_idx = '{0, 0, 0, 0};    vt[1].in_val = '{10'h3FF, 10'h0, 10'h0, 10'h0};
        vt[1].ex_idx = '{0, 0, 0, 0};    vt[1].ex_val = '{10'h0, 10'h0, 10'h0, 10'h0};
        vt[2].r = 5'd10;
        vt[2].in_idx = '{9, 10, 11, 0};  vt[2].in_val = '{10'h2AA, 10'h3FF, 10'h155, 10'h3FF};
        vt[2].ex_idx = '{10, 11, 1, 0};  vt[2].ex_val = '{10'h2AA, 10'h155, 10'h3FF, 10'h0};
        vt[3].r = 5'd5;
        vt[3].in_idx = '{0, 4, 5, 6};    vt[3].in_val = '{10'h001, 10'h3C0, 10'h3FF, 10'h300};
        vt[3].ex_idx = '{1, 5, 6, 0};    vt[3].ex_val = '{10'h001, 10'h3C0, 10'h300, 10'h0};
        vt[4].r = 5'd21;
        vt[4].in_idx = '{21, 0, 10, 0};  vt[4].in_val = '{10'h3FF, 10'h155, 10'h0F0, 10'h0};
        vt[4].ex_idx = '{1, 11, 0, 0};   vt[4].ex_val = '{10'h155, 10'h0F0, 10'h0, 10'h0};

        // reset state
        do_reset();
        #1;
        check("rst_board_out", board_out, 0);
        check("rst_board_we", board_we, 0);
        check("rst_busy", busy, 0);
        check("rst_score", score, 0);
        check("rst_scan_pause", scan_pause, 0);
        check("rst_state", dbg_state, IDLE);
        pause = 1'b1;
        #1;
        check("scan_pause_from_pause", scan_pause, 1);
        pause = 1'b0;

        // table of single clears
        for (int i = 0; i < 5; i++) begin
            b = '0;
            e = '0;
            for (int k = 0; k < 4; k++) begin
                b = put_row(b, vt[i].in_idx[k], vt[i].in_val[k]);
                e = put_row(e, vt[i].ex_idx[k], vt[i].ex_val[k]);
            end
            run_clear(vt[i].r, b, e);
        end

        // ignored requests: paused, then out-of-range rows
        @(negedge clk);
        pause      = 1'b1;
        full_valid = 1'b1;
        full_row   = 5'd3;
        board_in   = put_row('0, 3, 10'h3FF);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("paused_stays_idle", busy, 0);
        end
        @(negedge clk);
        pause = 1'b0;
        for (int i = 0; i < 6; i++) begin
            full_row = (i < 3) ? 5'd22 : 5'd31;
            @(posedge clk);
            #1;
            check("bad_row_stays_idle", busy, 0);
        end
        full_valid = 1'b0;
        check("ignored_score", score, exp_score);

        // back-to-back clears of rows 20 and 21
        do_reset();
        b0 = put_row('0, 21, 10'h3FF);
        b0 = put_row(b0, 20, 10'h3FF);
        b0 = put_row(b0, 19, 10'h0F0);
        b0 = put_row(b0, 0, 10'h001);
        e1 = put_row('0, 21, 10'h3FF);
        e1 = put_row(e1, 20, 10'h0F0);
        e1 = put_row(e1, 1, 10'h001);
        e2 = put_row('0, 21, 10'h0F0);
        e2 = put_row(e2, 2, 10'h001);
        run_clear(5'd21, b0, e1);
        run_clear(5'd21, e1, e2);
        check("b2b_score", score, 2);

        // reset asserted mid-shift
        @(negedge clk);
        board_in   = b0;
        full_row   = 5'd21;
        full_valid = 1'b1;
        @(posedge clk);
        #1;
        full_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_we", board_we, 0);
        check("async_rst_score", score, 0);
        check("async_rst_board", board_out, 0);
        check("async_rst_state", dbg_state, IDLE);
        exp_score = 0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 29) check("post_rst_idle", busy, 0);
        end

        // saturation: 16382 quick clears of row 0, then two checked ones
        do_reset();
        sb_en      = 1'b0;
        full_row   = 5'd0;
        board_in   = '0;
        full_valid = 1'b1;
        pulses     = 0;
        for (int i = 0; i < 80000 && pulses < 16382; i++) begin
            @(posedge clk);
            #1;
            if (board_we) pulses++;
        end
        full_valid = 1'b0;
        check("sat_pulses", pulses, 16382);
        repeat (2) @(posedge clk);
        #1;
        check("sat_preload_score", score, 16382);
        sb_en     = 1'b1;
        exp_score = 16382;
        run_clear(5'd0, put_row('0, 0, 10'h3FF), '0);
        run_clear(5'd0, put_row('0, 0, 10'h3FF), '0);
        check("sat_final_score", score, 16383);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
